// File: rtl/vip_frame_stream_gen.sv
// vip_frame_stream_gen: raster Bayer test-frame source (RGGB colour bars).
// Define VIP_SRC_GRADIENT_EN to replace the bars with a (col+row+frame_cnt) gradient.
`timescale 1ns/1ps
module vip_frame_stream_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int H_BLANK   = 160,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 10,
    parameter int V_FP      = 2,
    parameter int CLKEN_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       per_frame_vsync,
    output logic       per_frame_href,
    output logic       per_frame_clken,
    output logic [7:0] per_img_y,
    output logic       frame_done,
    output logic       busy,
    output logic [7:0] frame_cnt
);
    localparam int L  = H_ACTIVE + H_BLANK;
    localparam int BW = H_ACTIVE / 8;
    typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP} state_t;
    // Zero-length vertical sections are skipped by picking the next non-empty one.
    localparam state_t S_FIRST   = V_SYNC > 0 ? VSYNC : V_BP > 0 ? VBP : ACTIVE;
    localparam state_t S_POST_VS = V_BP > 0 ? VBP : ACTIVE;

    state_t      state, nxt;
    logic [31:0] div_cnt, cnt, len;
    logic [15:0] col, row, in_bar;
    logic [2:0]  bar;
    logic        tick, last, row_last, eof, comp;
    logic [7:0]  pix;

    always_comb begin
        tick     = div_cnt == '0;
        len      = state == VSYNC  ? 32'(V_SYNC * L) :
                   state == VBP    ? 32'(V_BP * L) :
                   state == ACTIVE ? 32'(H_ACTIVE) :
                   state == HBLANK ? 32'(H_BLANK) : 32'(V_FP * L);
        last     = tick && state != IDLE && cnt == len - 32'd1;
        row_last = row == 16'(V_ACTIVE - 1);
        eof      = last && (state == VFP || (state == HBLANK && row_last && V_FP == 0));
        nxt      = eof                          ? (enable ? S_FIRST : IDLE) :
                   state == VSYNC               ? S_POST_VS :
                   state == VBP                 ? ACTIVE :
                   state == ACTIVE              ? HBLANK :
                   (state == HBLANK && !row_last) ? ACTIVE : VFP;
        // Bar colour bits: R clear on bars 2,3,6,7; G clear on 4..7; B clear on odd bars.
        comp     = row[0] ? (col[0] ? ~bar[0] : ~bar[2]) : (col[0] ? ~bar[2] : ~bar[1]);
`ifdef VIP_SRC_GRADIENT_EN
        pix      = col[7:0] + row[7:0] + frame_cnt;
`else
        pix      = {8{comp}};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            div_cnt         <= '0;
            cnt             <= '0;
            col             <= '0;
            row             <= '0;
            in_bar          <= '0;
            bar             <= '0;
            per_frame_vsync <= 1'b0;
            per_frame_href  <= 1'b0;
            per_frame_clken <= 1'b0;
            per_img_y       <= '0;
            frame_done      <= 1'b0;
            busy            <= 1'b0;
            frame_cnt       <= '0;
        end else begin
            div_cnt <= (state == IDLE || div_cnt == 32'(CLKEN_DIV - 1)) ? '0 : div_cnt + 32'd1;
            if (state == IDLE) begin
                state <= enable ? S_FIRST : IDLE;
                cnt   <= '0;
            end else if (last) begin
                state <= nxt;
                cnt   <= '0;
            end else if (tick) begin
                cnt <= cnt + 32'd1;
            end
            if (state == ACTIVE && tick) begin
                col    <= col + 16'd1;
                in_bar <= in_bar == 16'(BW - 1) ? '0 : in_bar + 16'd1;
                bar    <= in_bar == 16'(BW - 1) ? bar + 3'd1 : bar;
            end else if (state != ACTIVE) begin
                col    <= '0;
                in_bar <= '0;
                bar    <= '0;
            end
            row <= (state == IDLE || eof) ? '0 : (state == HBLANK && last) ? row + 16'd1 : row;
            per_frame_vsync <= state == VSYNC;
            per_frame_href  <= state == ACTIVE;
            per_frame_clken <= state == ACTIVE && tick;
            per_img_y       <= (state == ACTIVE && tick) ? pix : per_img_y;
            frame_done      <= eof;
            busy            <= state != IDLE;
            frame_cnt       <= eof ? frame_cnt + 8'd1 : frame_cnt;
        end
    end
endmodule
